tick_gen_multi: RTL and testbench
=================================

# tick_gen_multi

Parametrised, multi-channel successor to the single 1 Hz strobe generator. It produces `NUM_CH` independent one-cycle tick strobes from the 50 MHz board clock. Each channel has a runtime-programmable divisor, and all channels share a global enable and a synchronous clear. It feeds the Lab timing tree: seconds counters, debounce sampling, display multiplexing and LED blink logic.

## Interface
- `NUM_CH`, default 4: number of tick channels, 1..8.
- `CNT_W`, default 32: counter and divisor width.
- `clk_50MHz` in 1: system clock, 50 MHz; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: global count enable; when 0, all counters hold.
- `clr` in 1: synchronous clear of all counters and outputs.
- `div_wr` in 1: divisor write strobe, one cycle.
- `div_sel` in `$clog2(NUM_CH)` (min 1): channel addressed by `div_wr`.
- `div_data` in `CNT_W`: new divisor value D; the tick period is D+1 cycles.
- `tick` out `NUM_CH`: per-channel one-cycle strobe.
- `square` out `NUM_CH`: per-channel toggle output; see Configuration.

## Operation
- Per channel: `cnt` (`CNT_W`), active divisor `div_act`, shadow divisor `div_shd`, `pend` flag, `tick` register, `square` register.
- Reset values:
  - `cnt` = 0, `tick` = 0, `square` = 0, `pend` = 0.
  - `div_act` = `div_shd` = `DEF_DIV[i]`: ch0 49_999_999 (1 Hz), ch1 4_999_999 (10 Hz), ch2 499_999 (100 Hz), ch3 49_999 (1 kHz). Channels ≥4 use 49_999.
- Priority per edge, highest first: `rst`, then `clr`, then `en`=0, then normal count.
- `clr`=1: `cnt`←0, `tick`←0, `square`←0, and `div_act`←`div_shd` if `pend`. The clear applies regardless of `en`.
- `en`=0: `cnt` holds, `square` holds, `tick`←0.
- `en`=1 and `cnt` ≠ `div_act`: `cnt`←`cnt`+1, `tick`←0.
- `en`=1 and `cnt` = `div_act` (terminal): `cnt`←0, `tick`←1, `square` toggles. If `pend`, then `div_act`←`div_shd` and `pend`←0.
- Divisor write: `div_wr`=1 with `div_sel` < `NUM_CH` loads `div_shd[div_sel]`←`div_data` and sets `pend`. Writes with `div_sel` ≥ `NUM_CH` are ignored.
- The new divisor takes effect only at the next terminal count or clear, so a running period is never truncated or stretched (glitch-free retune).
- A write in the same cycle as a terminal count on that channel lands in the shadow only. It takes effect at the following terminal count.
- Back-to-back writes to one channel before it applies: the last write wins.
- D=0 is legal: `tick` is held at 1 continuously while `en`=1.
- Counter never exceeds `div_act`, so no wrap-around beyond `CNT_W` occurs.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- From the first edge with `en`=1 after reset or clear, `cnt` reaches D after D edges. `tick` is high in the cycle after edge D+1.
- Tick period is exactly D+1 cycles; the pulse width is 1 cycle (except D=0).
- The `square` period is 2(D+1) cycles with 50% duty.
- `en` deassertion freezes phase. On reassertion, counting resumes from the held `cnt`, with no lost or extra tick.
- Channels are fully independent; a write to one channel never disturbs the phase of another.
- Reset asserted mid-period: all outputs drop to 0 asynchronously. Any pending shadow value is discarded and the defaults are restored.

## Configuration
- Macro `TICK_GEN_SQUARE_OUT_EN`.
- Defined: `square` registers and toggle logic are present as described above.
- Undefined: `square` is tied to 0 and no toggle flops are synthesised. `tick` behaviour is identical.

## Structure
- Package `tick_gen_pkg`:
  - `CLK_HZ` = 50_000_000.
  - `DEF_DIV` constant array and a function `hz_to_div(hz)` = `CLK_HZ`/hz − 1.
  - `MAX_CH` = 8.
- Sub-module `tick_chan` holds one channel: counter, active/shadow divisor, `pend`, `tick`, `square`. It has inputs `en`, `clr`, `wr`, `wdata`, and parameter `DEF`.
- The top-level instantiates `NUM_CH` copies via `generate` and decodes `div_sel`.

## Test plan
Bench overrides `DEF_DIV` with small values via `hz_to_div` or `defparam`, with ch0 D=4 and ch1 D=2.
- Release reset, `en`=1 → ch0 `tick` high on edges 5, 10, 15 and ch1 on edges 3, 6, 9; each pulse is 1 cycle.
- Write D=1 to ch0 at cycle 7 → next ch0 tick at edge 10 (old period), then at 12, 14.
- `en`=0 for 6 cycles starting with ch0 `cnt`=2 → no ticks. After reassertion, the ch0 tick comes 3 edges later.
- `clr` in the same cycle as the ch0 terminal count → no tick, `cnt`=0, next tick 5 edges after `clr` drops.
- `div_wr` with `div_sel`=7 and `NUM_CH`=4 → no channel changes; D=0 on ch1 → `tick[1]` is constant 1.
- With the macro defined, `square[0]` toggles every 5 cycles (period 10). With it undefined, `square`=0 throughout. Assert `rst` mid-period → all outputs are 0 immediately.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared constants for the multi-channel tick generator: clock rate, channel
// limit and the per-channel default divisors.
package tick_gen_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int          MAX_CH = 8;

  typedef logic [MAX_CH-1:0][31:0] div_arr_t;

  // Divisor D for a tick rate of hz; the period is D+1 clocks.
  function automatic logic [31:0] hz_to_div(input int unsigned hz);
    return 32'(CLK_HZ / hz - 1);
  endfunction

  // Packed with channel 7 first: ch0 1 Hz, ch1 10 Hz, ch2 100 Hz, ch3 and up 1 kHz.
  localparam div_arr_t DEF_DIV = {
    32'd49_999, 32'd49_999, 32'd49_999, 32'd49_999,
    32'd49_999, 32'd499_999, 32'd4_999_999, 32'd49_999_999
  };

endpackage

// File: rtl/tick_chan.sv
// One tick channel: up-counter against an active divisor, a shadow divisor
// applied at the next terminal count or clear, and tick/square strobes.
// The square toggle flop exists only when TICK_GEN_SQUARE_OUT_EN is defined.
module tick_chan #(
  parameter int               CNT_W = 32,
  parameter logic [CNT_W-1:0] DEF   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
  output logic             tick,
  output logic             square
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  logic             pend;
  logic             terminal;
  logic             apply;

  assign terminal = (cnt == div_act);
  // Shadow moves to active only on a period boundary, keeping retunes glitch-free.
  assign apply    = clr | (en & terminal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_act <= DEF;
      div_shd <= DEF;
      pend    <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (wr) div_shd <= wdata;
      if (apply && pend) div_act <= div_shd;
      // A write on the apply edge stays pending for the following boundary.
      if (wr)         pend <= 1'b1;
      else if (apply) pend <= 1'b0;

      if (clr) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (!en) begin
        tick <= 1'b0;
      end else if (terminal) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end
  end

`ifdef TICK_GEN_SQUARE_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                square <= 1'b0;
    else if (clr)              square <= 1'b0;
    else if (en && terminal)   square <= ~square;
  end
`else
  assign square = 1'b0;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// NUM_CH independent programmable tick strobes sharing enable and clear.
// Optional square outputs are enabled with TICK_GEN_SQUARE_OUT_EN.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int       NUM_CH   = 4,
  parameter int       CNT_W    = 32,
  parameter div_arr_t DEF_DIVS = DEF_DIV,
  localparam int      SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] square
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      logic wr;
      // Selects at or above NUM_CH match no channel and are dropped.
      assign wr = div_wr & (div_sel == SEL_W'(gi));

      tick_chan #(
        .CNT_W (CNT_W),
        .DEF   (CNT_W'(DEF_DIVS[gi]))
      ) u_chan (
        .clk    (clk_50MHz),
        .rst_n  (rst),
        .en     (en),
        .clr    (clr),
        .wr     (wr),
        .wdata  (div_data),
        .tick   (tick[gi]),
        .square (square[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi with small per-channel default divisors.
module tb_tick_gen_multi;
  import tick_gen_pkg::*;

  localparam int NCH = 5;
  localparam int CW  = 16;
  localparam int SW  = 3;
  localparam div_arr_t TB_DEFS = {32'd0, 32'd0, 32'd0, 32'd5, 32'd3, 32'd6, 32'd2, 32'd4};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           clr = 1'b0;
  logic           div_wr = 1'b0;
  logic [SW-1:0]  div_sel = '0;
  logic [CW-1:0]  div_data = '0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] square;

  int tests = 0;
  int fails = 0;

  tick_gen_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIVS(TB_DEFS)) dut (
    .clk_50MHz (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .div_wr    (div_wr),
    .div_sel   (div_sel),
    .div_data  (div_data),
    .tick      (tick),
    .square    (square)
  );

  always #5 clk = ~clk;

  // Reference model: countdown of edges remaining until the next tick.
  int             mdef [NCH] = '{4, 2, 6, 3, 5};
  int             m_act [NCH];
  int             m_shd [NCH];
  bit             m_pend [NCH];
  int             m_rem [NCH];
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_sq;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_act[i] = mdef[i]; m_shd[i] = mdef[i]; m_pend[i] = 0; m_rem[i] = mdef[i] + 1;
      end
      m_tick = '0; m_sq = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr) begin
          if (m_pend[i]) begin m_act[i] = m_shd[i]; m_pend[i] = 0; end
          m_rem[i] = m_act[i] + 1; m_tick[i] = 0; m_sq[i] = 0;
        end else if (!en) begin
          m_tick[i] = 0;
        end else begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            m_tick[i] = 1; m_sq[i] = ~m_sq[i];
            if (m_pend[i]) begin m_act[i] = m_shd[i]; m_pend[i] = 0; end
            m_rem[i] = m_act[i] + 1;
          end else m_tick[i] = 0;
        end
        if (div_wr && int'(div_sel) == i) begin m_shd[i] = int'(div_data); m_pend[i] = 1; end
      end
    end
  end

  function automatic logic [NCH-1:0] exp_sq();
`ifdef TICK_GEN_SQUARE_OUT_EN
    return m_sq;
`else
    return '0;
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; clr = 1'b0; div_wr = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    tests++;
    if (tick !== '0) begin fails++; $display("FAIL reset_tick got %b want 0", tick); end
    tests++;
    if (square !== '0) begin fails++; $display("FAIL reset_square got %b want 0", square); end
    en = 1'b1;
    cycle(); cycle();
    tests++;
    if (tick !== '0) begin fails++; $display("FAIL reset_hold_tick got %b want 0", tick); end
    rst = 1'b1; en = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_periods();
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      tests++;
      if (tick[0] !== (e % 5 == 0)) begin
        fails++; $display("FAIL period_ch0 edge %0d got %b want %b", e, tick[0], e % 5 == 0);
      end
      tests++;
      if (tick[1] !== (e % 3 == 0)) begin
        fails++; $display("FAIL period_ch1 edge %0d got %b want %b", e, tick[1], e % 3 == 0);
      end
    end
    $display("[TB] test_periods done");
  endtask

  task automatic test_retune();
    logic want;
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      if (e == 7) begin div_wr = 1'b1; div_sel = 3'd0; div_data = 16'd1; end
      cycle();
      div_wr = 1'b0;
      want = (e == 5 || e == 10 || e == 12 || e == 14 || e == 16);
      tests++;
      if (tick[0] !== want) begin
        fails++; $display("FAIL retune_ch0 edge %0d got %b want %b", e, tick[0], want);
      end
    end
    $display("[TB] test_retune done");
  endtask

  task automatic test_enable_hold();
    do_reset();
    en = 1'b1;
    cycle(); cycle();
    en = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cycle();
      tests++;
      if (tick !== '0) begin fails++; $display("FAIL hold_tick cycle %0d got %b want 0", e, tick); end
    end
    en = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      cycle();
      tests++;
      if (tick[0] !== (e == 3)) begin
        fails++; $display("FAIL resume_ch0 edge %0d got %b want %b", e, tick[0], e == 3);
      end
      if (e == 1) begin
        tests++;
        if (tick[1] !== 1'b1) begin fails++; $display("FAIL resume_ch1 got %b want 1", tick[1]); end
      end
    end
    $display("[TB] test_enable_hold done");
  endtask

  task automatic test_clear();
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 4; e++) cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    tests++;
    if (tick !== '0) begin fails++; $display("FAIL clr_tick got %b want 0", tick); end
    tests++;
    if (square !== '0) begin fails++; $display("FAIL clr_square got %b want 0", square); end
    for (int e = 1; e <= 5; e++) begin
      cycle();
      tests++;
      if (tick[0] !== (e == 5)) begin
        fails++; $display("FAIL clr_ch0 edge %0d got %b want %b", e, tick[0], e == 5);
      end
    end
    // Pending shadow is applied by clear.
    div_wr = 1'b1; div_sel = 3'd0; div_data = 16'd2;
    cycle();
    div_wr = 1'b0; clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cycle();
      tests++;
      if (tick[0] !== (e % 3 == 0)) begin
        fails++; $display("FAIL clr_apply_ch0 edge %0d got %b want %b", e, tick[0], e % 3 == 0);
      end
    end
    $display("[TB] test_clear done");
  endtask

  task automatic test_bad_sel();
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      if (e == 1)  begin div_wr = 1'b1; div_sel = 3'd7; div_data = 16'd0; end
      if (e == 16) begin div_wr = 1'b1; div_sel = 3'd1; div_data = 16'd0; end
      cycle();
      div_wr = 1'b0;
      tests++;
      if (tick[0] !== (e % 5 == 0)) begin
        fails++; $display("FAIL badsel_ch0 edge %0d got %b want %b", e, tick[0], e % 5 == 0);
      end
      tests++;
      if (tick[1] !== ((e >= 18) ? 1'b1 : (e % 3 == 0))) begin
        fails++; $display("FAIL badsel_ch1 edge %0d got %b", e, tick[1]);
      end
    end
    $display("[TB] test_bad_sel done");
  endtask

  task automatic test_square();
    logic want;
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      cycle();
`ifdef TICK_GEN_SQUARE_OUT_EN
      want = ((e / 5) % 2 == 1);
`else
      want = 1'b0;
`endif
      tests++;
      if (square[0] !== want) begin
        fails++; $display("FAIL square_ch0 edge %0d got %b want %b", e, square[0], want);
      end
    end
    $display("[TB] test_square done");
  endtask

  task automatic test_rst_mid();
    do_reset();
    en = 1'b1;
    div_wr = 1'b1; div_sel = 3'd0; div_data = 16'd1;
    cycle();
    div_wr = 1'b0;
    for (int e = 2; e <= 8; e++) cycle();
    #2 rst = 1'b0;
    #1;
    tests++;
    if (tick !== '0) begin fails++; $display("FAIL rstmid_tick got %b want 0", tick); end
    tests++;
    if (square !== '0) begin fails++; $display("FAIL rstmid_square got %b want 0", square); end
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      tests++;
      if (tick[0] !== (e % 5 == 0)) begin
        fails++; $display("FAIL rstmid_default edge %0d got %b want %b", e, tick[0], e % 5 == 0);
      end
    end
    $display("[TB] test_rst_mid done");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en       = ($urandom % 8) != 0;
      clr      = ($urandom % 40) == 0;
      div_wr   = ($urandom % 4) == 0;
      div_sel  = SW'($urandom % 8);
      div_data = CW'($urandom % 6);
      cycle();
      tests++;
      if (tick !== m_tick) begin
        fails++; $display("FAIL random_tick cycle %0d got %b want %b", c, tick, m_tick);
      end
      tests++;
      if (square !== exp_sq()) begin
        fails++; $display("FAIL random_square cycle %0d got %b want %b", c, square, exp_sq());
      end
    end
    en = 1'b0; clr = 1'b0; div_wr = 1'b0;
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_periods();
    test_retune();
    test_enable_hold();
    test_clear();
    test_bad_sel();
    test_square();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
